jericalla_fetch: RTL and testbench

Instruction issue unit that drives the 19-bit `instruction` bus of the jericalla pipelined datapath. It holds a small loadable program memory, sequences it with a program counter, and inserts NOP bubbles whenever an instruction reads a register written by an instruction still in flight, because the datapath has no forwarding. It sits directly upstream of the datapath and produces one instruction word per clock.

---
 rtl/jericalla_fetch.sv | 198 +++++++++++++++++++
 tb/tb_jericalla_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jericalla_fetch.sv
// jericalla_fetch: issues one instruction word per clock from a loadable program memory.
// Dependent readers are held behind NOP bubbles because the datapath has no forwarding.
module jericalla_fetch #(
  parameter int          PROG_DEPTH    = 64,
  parameter int          HAZARD_WINDOW = 2,
  parameter logic [3:0]  NOP_OPCODE    = 4'hF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(PROG_DEPTH):0]   prog_len,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [18:0]                   prog_wdata,
  output logic [18:0]                   instruction,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   issued_count,
  output logic [15:0]                   stall_count
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int DW = $clog2(HAZARD_WINDOW + 1);
  localparam logic [18:0] BUBBLE = {NOP_OPCODE, 15'b0};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [18:0]   mem_q [PROG_DEPTH];
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [18:0]   instr_q, instr_d;
  logic [15:0]   issued_q, issued_d;
  logic [15:0]   stall_q, stall_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [HAZARD_WINDOW-1:0] sb_v_q, sb_v_d;
  logic [4:0]               sb_wa_q [HAZARD_WINDOW];
  logic [4:0]               sb_wa_d [HAZARD_WINDOW];

  logic [18:0] cand;
  logic        cand_nop;
  logic        hazard;
  logic        last;
  logic        mem_we;
  logic        sb_clear;
  logic        sb_shift;
  logic        push_v;
  logic [4:0]  push_wa;

  assign cand     = mem_q[pc_q];
  assign cand_nop = (cand[18:15] == NOP_OPCODE);
  assign last     = ({1'b0, pc_q} == len_q - 1'b1);
  assign mem_we   = prog_we && (state_q == IDLE || state_q == DONE);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_WINDOW; i++) begin
      if (sb_v_q[i] &&
          (sb_wa_q[i] == cand[9:5] || sb_wa_q[i] == cand[4:0]))
        hazard = 1'b1;
    end
    if (cand_nop)
      hazard = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    instr_d  = BUBBLE;
    issued_d = issued_q;
    stall_d  = stall_q;
    drain_d  = drain_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    sb_clear = 1'b0;
    sb_shift = 1'b0;
    push_v   = 1'b0;
    push_wa  = 5'd0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = (prog_len > (AW+1)'(PROG_DEPTH)) ?
                     (AW+1)'(PROG_DEPTH) : prog_len;
          pc_d     = '0;
          issued_d = '0;
          stall_d  = '0;
          sb_clear = 1'b1;
          if (len_d == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        busy_d   = 1'b1;
        sb_shift = 1'b1;
        if (hazard) begin
          stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
        end else begin
          instr_d  = cand;
          push_v   = !cand_nop;
          push_wa  = cand[14:10];
          pc_d     = pc_q + 1'b1;
          issued_d = (issued_q == 16'hFFFF) ? issued_q : issued_q + 16'd1;
          if (last) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        busy_d   = 1'b1;
        sb_shift = 1'b1;
        drain_d  = drain_q + 1'b1;
        if (drain_q == DW'(HAZARD_WINDOW - 1))
          state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every issued non-NOP word is conservatively treated as a writer of wA.
  always_comb begin
    sb_v_d = sb_v_q;
    for (int i = 0; i < HAZARD_WINDOW; i++)
      sb_wa_d[i] = sb_wa_q[i];
    if (sb_clear) begin
      sb_v_d = '0;
    end else if (sb_shift) begin
      sb_v_d[0]  = push_v;
      sb_wa_d[0] = push_wa;
      for (int i = 1; i < HAZARD_WINDOW; i++) begin
        sb_v_d[i]  = sb_v_q[i-1];
        sb_wa_d[i] = sb_wa_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      instr_q  <= BUBBLE;
      issued_q <= '0;
      stall_q  <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sb_v_q   <= '0;
      for (int i = 0; i < HAZARD_WINDOW; i++)
        sb_wa_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      instr_q  <= instr_d;
      issued_q <= issued_d;
      stall_q  <= stall_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sb_v_q   <= sb_v_d;
      for (int i = 0; i < HAZARD_WINDOW; i++)
        sb_wa_q[i] <= sb_wa_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[prog_addr] <= prog_wdata;
  end

  assign instruction  = instr_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign issued_count = issued_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_jericalla_fetch.sv
// Directed bench for jericalla_fetch: hand-computed issue sequences,
// hazard bubbles, drain/done timing, reset and write protection.
module tb_jericalla_fetch;

  localparam logic [18:0] BUB = {4'hF, 15'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  prog_len;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [18:0] prog_wdata;
  logic [18:0] instruction;
  logic [5:0]  pc;
  logic        busy;
  logic        done;
  logic [15:0] issued_count;
  logic [15:0] stall_count;

  int ncmp = 0;
  int nfail = 0;

  logic [18:0] i0, i1, i2, wnew;

  jericalla_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .prog_len     (prog_len),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_wdata   (prog_wdata),
    .instruction  (instruction),
    .pc           (pc),
    .busy         (busy),
    .done         (done),
    .issued_count (issued_count),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic [3:0] op,
                                     input logic [4:0] wa,
                                     input logic [4:0] r1,
                                     input logic [4:0] r2);
    return {op, wa, r1, r2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [5:0] a, input logic [18:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    tick();
    prog_we    = 1'b0;
  endtask

  task automatic run_start(input logic [6:0] len);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, n, exp_edges);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_len = '0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_instr", instruction, BUB);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_stall", stall_count, 0);

    for (int a = 0; a < 64; a++)
      write(6'(a), BUB);

    // Independent program
    i0 = mk(4'h1, 5'd1, 5'd4, 5'd5);
    i1 = mk(4'h2, 5'd2, 5'd6, 5'd7);
    i2 = mk(4'h3, 5'd3, 5'd4, 5'd7);
    write(6'd0, i0); write(6'd1, i1); write(6'd2, i2);
    run_start(7'd3);
    chk("ind_busy_e0", busy, 1);
    tick(); chk("ind_e1", instruction, i0);
    chk("ind_pc_e1", pc, 1);
    tick(); chk("ind_e2", instruction, i1);
    tick(); chk("ind_e3", instruction, i2);
    tick(); chk("ind_e4", instruction, BUB);
    tick(); chk("ind_e5", instruction, BUB);
    chk("ind_done_e5", done, 0);
    chk("ind_busy_e5", busy, 1);
    tick(); chk("ind_done_e6", done, 1);
    chk("ind_busy_e6", busy, 0);
    chk("ind_issued", issued_count, 3);
    chk("ind_stall", stall_count, 0);
    tick(); chk("ind_done_e7", done, 0);

    // Back-to-back RAW
    i0 = mk(4'h1, 5'd5, 5'd1, 5'd2);
    i1 = mk(4'h2, 5'd6, 5'd5, 5'd3);
    write(6'd0, i0); write(6'd1, i1);
    run_start(7'd2);
    tick(); chk("b2b_e1", instruction, i0);
    tick(); chk("b2b_e2", instruction, BUB);
    tick(); chk("b2b_e3", instruction, BUB);
    tick(); chk("b2b_e4", instruction, i1);
    wait_done("b2b_done_edges", 3);
    chk("b2b_stall", stall_count, 2);
    chk("b2b_issued", issued_count, 2);

    // Distance-2 RAW
    i0 = mk(4'h1, 5'd5, 5'd1, 5'd2);
    i1 = mk(4'h2, 5'd6, 5'd7, 5'd8);
    i2 = mk(4'h3, 5'd7, 5'd9, 5'd5);
    write(6'd0, i0); write(6'd1, i1); write(6'd2, i2);
    run_start(7'd3);
    tick(); chk("d2_e1", instruction, i0);
    tick(); chk("d2_e2", instruction, i1);
    tick(); chk("d2_e3", instruction, BUB);
    tick(); chk("d2_e4", instruction, i2);
    wait_done("d2_done_edges", 3);
    chk("d2_stall", stall_count, 1);

    // Program NOP as a separating slot
    i1 = BUB;
    i2 = mk(4'h3, 5'd7, 5'd5, 5'd9);
    write(6'd1, i1); write(6'd2, i2);
    run_start(7'd3);
    tick(); chk("nop_e1", instruction, i0);
    tick(); chk("nop_e2", instruction, BUB);
    tick(); chk("nop_e3", instruction, BUB);
    tick(); chk("nop_e4", instruction, i2);
    wait_done("nop_done_edges", 3);
    chk("nop_stall", stall_count, 1);
    chk("nop_issued", issued_count, 3);

    // Zero length
    run_start(7'd0);
    chk("zero_busy_e0", busy, 0);
    chk("zero_done_e0", done, 0);
    wait_done("zero_done_edges", 1);
    chk("zero_issued", issued_count, 0);
    chk("zero_stall", stall_count, 0);

    // Oversized length clamps to 64 words
    run_start(7'd100);
    wait_done("len100_done_edges", 68);
    chk("len100_issued", issued_count, 64);
    chk("len100_stall", stall_count, 1);

    // Reset during the third RUN cycle
    i0 = mk(4'h1, 5'd1, 5'd4, 5'd5);
    i1 = mk(4'h2, 5'd2, 5'd6, 5'd7);
    i2 = mk(4'h3, 5'd3, 5'd4, 5'd7);
    write(6'd0, i0); write(6'd1, i1); write(6'd2, i2);
    run_start(7'd3);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_instr", instruction, BUB);
    chk("mrst_pc", pc, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_issued", issued_count, 0);
    chk("mrst_stall", stall_count, 0);
    run_start(7'd3);
    tick(); chk("mrst_rerun_e1", instruction, i0);
    wait_done("mrst_done_edges", 5);

    // Writes during RUN are ignored
    run_start(7'd3);
    prog_we = 1'b1; prog_addr = 6'd0;
    prog_wdata = mk(4'h9, 5'd9, 5'd9, 5'd9);
    tick(); tick();
    prog_we = 1'b0;
    wait_done("wp_done_edges", 4);
    run_start(7'd1);
    tick(); chk("wp_mem0", instruction, i0);
    wait_done("wp2_done_edges", 3);

    // Write and start in the same IDLE cycle
    wnew = mk(4'h8, 5'd10, 5'd11, 5'd12);
    prog_we = 1'b1; prog_addr = 6'd0; prog_wdata = wnew;
    run_start(7'd1);
    prog_we = 1'b0;
    tick(); chk("ws_mem0", instruction, wnew);
    wait_done("ws_done_edges", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
